// File: rtl/aska_pkg.sv
// Shared constants, frame packing and FSM state encoding for the ASKA SPI master.
package aska_pkg;

    localparam int ASKA_FRAME_BITS = 128;
    localparam int ASKA_WORD_BITS  = 32;

    // Word placement inside the frame; conf0 leaves the wire first.
    localparam int ASKA_CONF0_LSB = 96;
    localparam int ASKA_CONF1_LSB = 64;
    localparam int ASKA_ELE1_LSB  = 32;
    localparam int ASKA_ELE2_LSB  = 0;

    typedef enum logic [2:0] {
        SPIM_IDLE = 3'd0,
        SPIM_LOW  = 3'd1,
        SPIM_HIGH = 3'd2,
        SPIM_TAIL = 3'd3,
        SPIM_GAP  = 3'd4
    } aska_spim_state_t;

    function automatic logic [ASKA_FRAME_BITS-1:0] aska_pack_frame(
        input logic [ASKA_WORD_BITS-1:0] c0,
        input logic [ASKA_WORD_BITS-1:0] c1,
        input logic [ASKA_WORD_BITS-1:0] e1,
        input logic [ASKA_WORD_BITS-1:0] e2
    );
        logic [ASKA_FRAME_BITS-1:0] f;
        f = '0;
        f[ASKA_CONF0_LSB +: ASKA_WORD_BITS] = c0;
        f[ASKA_CONF1_LSB +: ASKA_WORD_BITS] = c1;
        f[ASKA_ELE1_LSB  +: ASKA_WORD_BITS] = e1;
        f[ASKA_ELE2_LSB  +: ASKA_WORD_BITS] = e2;
        return f;
    endfunction

endpackage

// File: rtl/aska_spim_tick.sv
// Half-period phase counter: one-cycle tick every HALF_PERIOD clk cycles,
// held at zero while clr_i is asserted (master idle).
module aska_spim_tick #(
    parameter int HALF_PERIOD = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr_i,
    output logic tick_o
);

    localparam int PW = $clog2(HALF_PERIOD + 1);
    localparam logic [PW-1:0] LAST = PW'(HALF_PERIOD - 1);

    logic [PW-1:0] phase_q, phase_d;

    assign tick_o = ~clr_i & (phase_q == LAST);

    always_comb begin
        phase_d = phase_q;
        if (clr_i || (phase_q == LAST)) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/aska_spi_master.sv
// SPI mode 0 master sending {conf0,conf1,ele1,ele2} as one 128-bit MSB-first frame.
// Optional ASKA_SPIM_LOOPBACK_EN adds SPI_MISO capture with rx_data / rx_match.
//
// state | meaning
// IDLE  | waiting for start, CS high
// LOW   | SPI_Clk low half period, MOSI stable
// HIGH  | SPI_Clk high half period, slave samples
// TAIL  | CS hold after the last falling edge
// GAP   | CS high before done
module aska_spi_master
    import aska_pkg::*;
#(
    parameter int HALF_PERIOD = 4,
    parameter int GAP_CYCLES  = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [ASKA_WORD_BITS-1:0] conf0,
    input  logic [ASKA_WORD_BITS-1:0] conf1,
    input  logic [ASKA_WORD_BITS-1:0] ele1,
    input  logic [ASKA_WORD_BITS-1:0] ele2,
    output logic                      busy,
    output logic                      done,
    output logic                      SPI_CS,
    output logic                      SPI_Clk,
    output logic                      SPI_MOSI
`ifdef ASKA_SPIM_LOOPBACK_EN
    ,
    input  logic                       SPI_MISO,
    output logic [ASKA_FRAME_BITS-1:0] rx_data,
    output logic                       rx_match
`endif
);

    localparam logic [2:0] ST_IDLE = SPIM_IDLE;
    localparam logic [2:0] ST_LOW  = SPIM_LOW;
    localparam logic [2:0] ST_HIGH = SPIM_HIGH;
    localparam logic [2:0] ST_TAIL = SPIM_TAIL;
    localparam logic [2:0] ST_GAP  = SPIM_GAP;

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [6:0] LAST_BIT = 7'(ASKA_FRAME_BITS - 1);

    logic [2:0]                 state_q, state_d;
    logic [ASKA_FRAME_BITS-1:0] shift_q, shift_d;
    logic [6:0]                 bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]              gap_cnt_q, gap_cnt_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       cs_q, cs_d;
    logic                       sclk_q, sclk_d;
    logic                       mosi_q, mosi_d;
    logic                       tick;
    logic                       accept;

    assign accept = (state_q == ST_IDLE) && start;

    aska_spim_tick #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .clr_i  (state_q == ST_IDLE),
        .tick_o (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cs_d      = cs_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOW;
                    shift_d   = aska_pack_frame(conf0, conf1, ele1, ele2);
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                    cs_d      = 1'b0;
                    sclk_d    = 1'b0;
                    mosi_d    = conf0[ASKA_WORD_BITS-1];
                end
            end
            ST_LOW: begin
                if (tick) begin
                    state_d = ST_HIGH;
                    sclk_d  = 1'b1;
                end
            end
            ST_HIGH: begin
                if (tick) begin
                    sclk_d = 1'b0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_TAIL;
                    end else begin
                        // next bit is presented together with the falling edge
                        state_d   = ST_LOW;
                        bit_cnt_d = bit_cnt_q + 7'd1;
                        shift_d   = {shift_q[ASKA_FRAME_BITS-2:0], 1'b0};
                        mosi_d    = shift_q[ASKA_FRAME_BITS-2];
                    end
                end
            end
            ST_TAIL: begin
                if (tick) begin
                    state_d   = ST_GAP;
                    cs_d      = 1'b1;
                    mosi_d    = 1'b0;
                    gap_cnt_d = GW'(GAP_CYCLES - 1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cs_q      <= cs_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign SPI_CS   = cs_q;
    assign SPI_Clk  = sclk_q;
    assign SPI_MOSI = mosi_q;

`ifdef ASKA_SPIM_LOOPBACK_EN
    logic [ASKA_FRAME_BITS-1:0] frame_q, frame_d;
    logic [ASKA_FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [ASKA_FRAME_BITS-1:0] rx_data_q, rx_data_d;
    logic                       rx_match_q, rx_match_d;

    // MISO is taken on the same clk edge that raises SPI_Clk
    always_comb begin
        frame_d    = frame_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_match_d = rx_match_q;
        if (accept) begin
            frame_d = aska_pack_frame(conf0, conf1, ele1, ele2);
        end
        if ((state_q == ST_LOW) && tick) begin
            rx_shift_d = {rx_shift_q[ASKA_FRAME_BITS-2:0], SPI_MISO};
        end
        if (done_d) begin
            rx_data_d  = rx_shift_q;
            rx_match_d = (rx_shift_q == frame_q);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_q    <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_match_q <= 1'b0;
        end else begin
            frame_q    <= frame_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_match_q <= rx_match_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_match = rx_match_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_aska_spi_master.sv
// Scoreboard bench for aska_spi_master: default instance (4/8) and a fast one (1/1).
`timescale 1ns/1ps
module tb_aska_spi_master;

    localparam int HP0 = 4, GAP0 = 8, HP1 = 1, GAP1 = 1;

    typedef struct {
        logic [127:0] frame;
        int           s;
        bit           inv;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] conf0 = '0, conf1 = '0, ele1 = '0, ele2 = '0;
    logic        busy[2], done[2], cs[2], sclk[2], mosi[2];

    int cyc = 0;
    int n_vec = 0, n_err = 0;
    exp_t exp_q[2][$];
    int   next_free[2] = '{0, 0};
    bit   inv_next = 1'b0;

    int           nbits[2], pend[2], busy_cnt[2];
    logic [127:0] bits[2];
    exp_t         cur[2];
    bit           have_cur[2] = '{0, 0};
    logic [127:0] last_frame[2];
    bit           last_inv[2];
    logic         prev_cs[2], prev_clk[2], prev_done[2];
    bit           rise_bad[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int hp(int i);
        return (i == 0) ? HP0 : HP1;
    endfunction

    function automatic int gap(int i);
        return (i == 0) ? GAP0 : GAP1;
    endfunction

`ifdef ASKA_SPIM_LOOPBACK_EN
    logic         miso[2];
    logic [127:0] rx_data[2];
    logic         rx_match[2];
    assign miso[0] = mosi[0] ^ (have_cur[0] & cur[0].inv & (nbits[0] == 127));
    assign miso[1] = mosi[1] ^ (have_cur[1] & cur[1].inv & (nbits[1] == 127));
`endif

    aska_spi_master #(.HALF_PERIOD(HP0), .GAP_CYCLES(GAP0)) u_dut0 (
        .clk(clk), .resetn(resetn), .start(start),
        .conf0(conf0), .conf1(conf1), .ele1(ele1), .ele2(ele2),
        .busy(busy[0]), .done(done[0]), .SPI_CS(cs[0]), .SPI_Clk(sclk[0]), .SPI_MOSI(mosi[0])
`ifdef ASKA_SPIM_LOOPBACK_EN
        , .SPI_MISO(miso[0]), .rx_data(rx_data[0]), .rx_match(rx_match[0])
`endif
    );

    aska_spi_master #(.HALF_PERIOD(HP1), .GAP_CYCLES(GAP1)) u_dut1 (
        .clk(clk), .resetn(resetn), .start(start),
        .conf0(conf0), .conf1(conf1), .ele1(ele1), .ele2(ele2),
        .busy(busy[1]), .done(done[1]), .SPI_CS(cs[1]), .SPI_Clk(sclk[1]), .SPI_MOSI(mosi[1])
`ifdef ASKA_SPIM_LOOPBACK_EN
        , .SPI_MISO(miso[1]), .rx_data(rx_data[1]), .rx_match(rx_match[1])
`endif
    );

    task automatic check(string name, int i, logic [127:0] act, logic [127:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s[%0d] @%0d: got %h expected %h", name, i, cyc, act, expv);
        end
    endtask

    task automatic fail(string name, int i);
        n_vec++;
        n_err++;
        $display("FAIL %s[%0d] @%0d: event not expected / not seen", name, i, cyc);
    endtask

    // Slave model and scoreboard: reassembles frames and times every edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!resetn) begin
                nbits[i] = 0; pend[i] = -1; have_cur[i] = 0; rise_bad[i] = 0;
                prev_cs[i] = 1'b1; prev_clk[i] = 1'b0; prev_done[i] = 1'b0;
            end else begin
                if (prev_done[i] && done[i]) fail("done_width", i);
                if (prev_cs[i] && !cs[i]) begin
                    nbits[i] = 0; bits[i] = '0; rise_bad[i] = 0; busy_cnt[i] = 0;
                    if (exp_q[i].size() == 0) begin
                        fail("unexpected_frame", i);
                    end else begin
                        cur[i] = exp_q[i].pop_front();
                        have_cur[i] = 1;
                        check("cs_fall_edge", i, cyc, cur[i].s);
                    end
                end
                if (busy[i]) busy_cnt[i]++;
                if (!prev_clk[i] && sclk[i]) begin
                    if (!have_cur[i] || cs[i]) rise_bad[i] = 1;
                    else if (cyc != cur[i].s + (2 * nbits[i] + 1) * hp(i)) rise_bad[i] = 1;
                    bits[i] = {bits[i][126:0], mosi[i]};
                    nbits[i]++;
                end
                if (!prev_cs[i] && cs[i] && have_cur[i]) begin
                    check("frame_bits", i, bits[i], cur[i].frame);
                    check("bit_count", i, nbits[i], 128);
                    check("clk_timing_ok", i, rise_bad[i], 0);
                    check("cs_rise_edge", i, cyc, cur[i].s + 257 * hp(i));
                    pend[i] = cur[i].s + 257 * hp(i) + gap(i);
                    last_frame[i] = cur[i].frame;
                    last_inv[i] = cur[i].inv;
                    have_cur[i] = 0;
                end
                if (done[i] && !prev_done[i]) begin
                    if (pend[i] < 0) begin
                        fail("spurious_done", i);
                    end else begin
                        check("done_edge", i, cyc, pend[i]);
                        check("busy_at_done", i, busy[i], 0);
                        check("busy_cycles", i, busy_cnt[i], 257 * hp(i) + gap(i));
`ifdef ASKA_SPIM_LOOPBACK_EN
                        check("rx_data", i, rx_data[i], last_frame[i] ^ (last_inv[i] ? 128'd1 : 128'd0));
                        check("rx_match", i, rx_match[i], !last_inv[i]);
`endif
                        pend[i] = -1;
                    end
                end
                prev_cs[i] = cs[i]; prev_clk[i] = sclk[i]; prev_done[i] = done[i];
            end
        end
    end

    task automatic rnd_words();
        conf0 = $urandom; conf1 = $urandom; ele1 = $urandom; ele2 = $urandom;
    endtask

    // Reference: a start sampled while a frame is free is accepted; a frame
    // occupies the master for 257*HP + GAP edges plus the done cycle.
    task automatic step(bit st);
        start = st;
        for (int i = 0; i < 2; i++) begin
            if (st && resetn && (cyc + 1 >= next_free[i])) begin
                exp_t e;
                e.frame = {conf0, conf1, ele1, ele2};
                e.s = cyc + 1;
                e.inv = inv_next;
                exp_q[i].push_back(e);
                next_free[i] = cyc + 1 + 257 * hp(i) + gap(i) + 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            rnd_words();
            step(1'b0);
        end
    endtask

    task automatic check_reset_outputs(string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_busy"}, i, busy[i], 0);
            check({tag, "_done"}, i, done[i], 0);
            check({tag, "_cs"},   i, cs[i], 1);
            check({tag, "_sclk"}, i, sclk[i], 0);
            check({tag, "_mosi"}, i, mosi[i], 0);
`ifdef ASKA_SPIM_LOOPBACK_EN
            check({tag, "_rx_data"},  i, rx_data[i], 0);
            check({tag, "_rx_match"}, i, rx_match[i], 0);
`endif
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout[0] @%0d: bench did not finish", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int budget;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;
        @(negedge clk);

        conf0 = 32'hA5A5_0001; conf1 = 32'h0010_0C21; ele1 = 32'h0000_000F; ele2 = 32'hF000_0000;
        step(1'b1);
        idle(1100);

        repeat (2600) begin
            rnd_words();
            inv_next = ($urandom_range(0, 3) == 0);
            step(1'b1);
        end
        inv_next = 1'b0;
        idle(1100);

        // start on the done cycle of the default instance, then one cycle later
        rnd_words();
        step(1'b1);
        budget = 0;
        while ((cyc + 1 < next_free[0] - 1) && budget < 2000) begin
            rnd_words();
            step(1'b0);
            budget++;
        end
        rnd_words(); step(1'b1);
        rnd_words(); step(1'b1);
        idle(1100);

        repeat (3000) begin
            rnd_words();
            step($urandom_range(0, 39) == 0);
        end
        idle(1100);

        // reset in the middle of a frame
        rnd_words();
        step(1'b1);
        budget = 0;
        while (nbits[0] < 60 && budget < 2000) begin
            rnd_words();
            step(1'b0);
            budget++;
        end
        if (budget >= 2000) fail("wait_bit60", 0);
        #2 resetn = 1'b0;
        #1 check_reset_outputs("midreset");
        for (int i = 0; i < 2; i++) begin
            exp_q[i].delete();
            next_free[i] = 0;
        end
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        idle(1100);
        rnd_words();
        step(1'b1);
        idle(1100);

        for (int i = 0; i < 2; i++) begin
            check("drain_queue", i, exp_q[i].size(), 0);
            check("drain_done", i, pend[i], -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
